// File: rtl/char_dot_serializer.sv
// Serializer behind a 2513 character generator: fetches {code,row} dot rows, shifts
// them out one dot per dot enable with a blank inter-character gap and a blinking cursor.
module char_dot_serializer #(
    parameter int CELL_W       = 6,
    parameter int COLS         = 40,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       line_start,
    input  logic       frame_start,
    input  logic [2:0] row,
    input  logic [5:0] char_code,
    input  logic       cursor_here,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [8:0] rom_a,
    input  logic [4:0] rom_x,
    output logic       video,
    output logic       active,
    output logic       underrun
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DOT_W = $clog2(CELL_W);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [DOT_W-1:0] LAST_DOT   = DOT_W'(CELL_W - 1);
    localparam logic [BLK_W-1:0] LAST_BLINK = BLK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state_r;
    logic [2:0]        row_r;
    logic [COL_W-1:0]  col_r;
    logic [DOT_W-1:0]  dot_cnt_r;
    logic [CELL_W-1:0] sr_r;
    logic              have_next_r;
    logic              active_r;
    logic [BLK_W-1:0]  blink_cnt_r;
    logic              phase_r;

    logic              cell_end_s;
    logic              xfer_s;
    logic [5:0]        xfer_code_s;
    logic [CELL_W-1:0] load_val_s;

    // sr is held at zero outside ACTIVE, so its MSB is the video dot directly
    assign video       = sr_r[CELL_W-1];
    assign active      = active_r;
    assign xfer_s      = char_valid && char_ready;
    assign xfer_code_s = (cursor_here && phase_r) ? 6'h00 : char_code;

    // Handshake: one prefetch slot, never filled on the edge that ends a cell
    always_comb begin
        cell_end_s = dot_en && (dot_cnt_r == LAST_DOT);
        if (reset || have_next_r || cell_end_s) begin
            char_ready = 1'b0;
        end else if (state_r == PRIME) begin
            char_ready = 1'b1;
        end else if (state_r == ACTIVE) begin
            char_ready = (col_r < LAST_COL);
        end else begin
            char_ready = 1'b0;
        end
    end

    // Generator row lands left-justified; the remaining low bits form the gap
    always_comb begin
        load_val_s                 = '0;
        load_val_s[CELL_W-1 -: 5]  = rom_x;
    end

    // Line sequencer, prefetch slot, blink phase and underrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            row_r       <= 3'd0;
            col_r       <= '0;
            dot_cnt_r   <= '0;
            sr_r        <= '0;
            have_next_r <= 1'b0;
            active_r    <= 1'b0;
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
            underrun    <= 1'b0;
            rom_a       <= 9'h100;
        end else begin
            if (frame_start) begin
                underrun <= 1'b0;
                if (blink_cnt_r == LAST_BLINK) begin
                    blink_cnt_r <= '0;
                    phase_r     <= ~phase_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BLK_W'(1);
                end
            end

            if (xfer_s) begin
                rom_a       <= {xfer_code_s, row_r};
                have_next_r <= 1'b1;
            end

            if (line_start) begin
                // dot_cnt is cleared too so a stale end-of-cell count cannot stall PRIME
                row_r       <= row;
                col_r       <= '0;
                dot_cnt_r   <= '0;
                have_next_r <= 1'b0;
                sr_r        <= '0;
                active_r    <= 1'b0;
                state_r     <= PRIME;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    PRIME: begin
                        if (dot_en && have_next_r) begin
                            sr_r        <= load_val_s;
                            dot_cnt_r   <= '0;
                            have_next_r <= 1'b0;
                            active_r    <= 1'b1;
                            state_r     <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (dot_en) begin
                            if (dot_cnt_r != LAST_DOT) begin
                                sr_r      <= {sr_r[CELL_W-2:0], 1'b0};
                                dot_cnt_r <= dot_cnt_r + DOT_W'(1);
                            end else if (col_r == LAST_COL) begin
                                sr_r     <= '0;
                                active_r <= 1'b0;
                                state_r  <= IDLE;
                            end else begin
                                if (have_next_r) begin
                                    sr_r        <= load_val_s;
                                    have_next_r <= 1'b0;
                                end else begin
                                    sr_r     <= '0;
                                    underrun <= 1'b1;
                                end
                                col_r     <= col_r + COL_W'(1);
                                dot_cnt_r <= '0;
                            end
                        end
                    end
                    default: begin
                        sr_r     <= '0;
                        active_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_char_dot_serializer.sv
// Bench for char_dot_serializer: directed cases with literal dot/address expectations,
// then random traffic, all checked each cycle against a cell/dot-position model.
module tb_char_dot_serializer;

    localparam int CELL_W = 6;
    localparam int COLS   = 2;
    localparam int BLINK  = 2;

    logic       clk, reset, dot_en, line_start, frame_start, cursor_here, char_valid;
    logic [2:0] row;
    logic [5:0] char_code;
    logic       char_ready, video, active, underrun;
    logic [8:0] rom_a;
    logic [4:0] rom_x;

    char_dot_serializer #(.CELL_W(CELL_W), .COLS(COLS), .BLINK_FRAMES(BLINK)) dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .line_start(line_start),
        .frame_start(frame_start), .row(row), .char_code(char_code),
        .cursor_here(cursor_here), .char_valid(char_valid), .char_ready(char_ready),
        .rom_a(rom_a), .rom_x(rom_x), .video(video), .active(active), .underrun(underrun)
    );

    // Character generator stub: known glyph rows plus an arbitrary hash elsewhere
    function automatic logic [4:0] rom_fn(input logic [8:0] a);
        logic [8:0] h;
        case (a)
            9'h009:  return 5'b00100;
            9'h049:  return 5'b01110;
            9'h011:  return 5'b11110;
            9'h001:  return 5'b01110;
            default: begin
                h = (a * 9'd37) ^ {a[3:0], a[8:4]};
                return h[4:0];
            end
        endcase
    endfunction
    assign rom_x = rom_fn(rom_a);

    int n_checks = 0, n_fail = 0, cyc = 0, dot_every = 1;
    bit chk_en = 1'b0, rand_mode = 1'b0;
    logic [6:0] feed[$];
    logic       cap[$];
    logic [8:0] hist[$];
    logic [8:0] last_rom = 9'h000;

    // Model: mode 0 idle, 1 priming, 2 running; a cell is a glyph plus a dot position
    int m_mode = 0, m_cell = 0, m_pos = 0, m_frames = 0;
    logic [2:0] m_row = 3'd0;
    logic [4:0] m_pat = 5'd0;
    logic       m_pend = 1'b0, m_under = 1'b0;
    logic [8:0] m_rom_a = 9'h100;

    function automatic logic m_ready();
        if (reset || m_pend) return 1'b0;
        if (dot_en && m_pos == CELL_W - 1) return 1'b0;
        if (m_mode == 1) return 1'b1;
        if (m_mode == 2 && m_cell < COLS - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        logic xfer, pend0, phase;
        logic [8:0] ra0;
        if (reset) begin
            m_mode = 0; m_cell = 0; m_pos = 0; m_frames = 0; m_row = 3'd0;
            m_pat = 5'd0; m_pend = 1'b0; m_under = 1'b0; m_rom_a = 9'h100;
        end else begin
            xfer  = char_valid && m_ready();
            pend0 = m_pend;
            ra0   = m_rom_a;
            phase = ((m_frames / BLINK) % 2) == 1;
            if (frame_start) begin
                m_frames++;
                m_under = 1'b0;
            end
            if (xfer) begin
                m_rom_a = {(cursor_here && phase) ? 6'h00 : char_code, m_row};
                m_pend  = 1'b1;
            end
            if (line_start) begin
                m_row = row; m_cell = 0; m_pos = 0; m_pend = 1'b0; m_mode = 1;
            end else if (m_mode == 1) begin
                if (dot_en && pend0) begin
                    m_pat = rom_fn(ra0); m_pos = 0; m_pend = 1'b0; m_mode = 2;
                end
            end else if (m_mode == 2 && dot_en) begin
                if (m_pos < CELL_W - 1) begin
                    m_pos++;
                end else if (m_cell == COLS - 1) begin
                    m_mode = 0;
                end else begin
                    if (pend0) begin
                        m_pat  = rom_fn(ra0);
                        m_pend = 1'b0;
                    end else begin
                        m_pat   = 5'd0;
                        m_under = 1'b1;
                    end
                    m_cell++;
                    m_pos = 0;
                end
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        logic ev;
        ev = (m_mode == 2 && m_pos < 5) ? m_pat[4 - m_pos] : 1'b0;
        check("video", video, ev);
        check("active", active, m_mode == 2);
        check("char_ready", char_ready, m_ready());
        check("rom_a", rom_a, m_rom_a);
        check("underrun", underrun, m_under);
    endtask

    // One clock: compare mid-cycle, step the model on the edge, drive just after it
    task automatic tick();
        logic took;
        @(negedge clk);
        if (chk_en) compare_all();
        if (active) cap.push_back(video);
        if (rom_a !== last_rom) begin
            hist.push_back(rom_a);
            last_rom = rom_a;
        end
        took = char_valid && char_ready;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (took && !rand_mode && feed.size() > 0) feed.delete(0);
        line_start  = 1'b0;
        frame_start = 1'b0;
        if (rand_mode) begin
            reset       = ($urandom_range(399) == 0);
            dot_en      = ($urandom_range(3) != 0);
            row         = 3'($urandom);
            frame_start = ($urandom_range(39) == 0);
            line_start  = ($urandom_range(59) == 0);
            char_valid  = !line_start && ($urandom_range(2) != 0);
            char_code   = 6'($urandom);
            cursor_here = ($urandom_range(3) == 0);
        end else begin
            dot_en     = (cyc % dot_every) == 0;
            char_valid = feed.size() > 0;
            if (feed.size() > 0) {cursor_here, char_code} = feed[0];
        end
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        char_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
    endtask

    task automatic run_line(input string nm);
        int n;
        n = 0;
        while (!(cap.size() > 0 && !active) && n < 400) begin
            tick();
            n++;
        end
        check({nm, "_done"}, n < 400, 1'b1);
    endtask

    task automatic check_dots(input string nm, input logic [11:0] pat, input int rep,
                              input int exp_len, input int ndots);
        check({nm, "_len"}, cap.size(), exp_len);
        for (int i = 0; i < ndots * rep; i++) begin
            if (i < cap.size()) check(nm, cap[i], pat[11 - i / rep]);
        end
    endtask

    task automatic start_line(input logic [6:0] a, input logic [6:0] b, input bit two);
        feed.push_back(a);
        if (two) feed.push_back(b);
        cap.delete();
        hist.delete();
        pulse_line();
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        logic [11:0] pat5;
        int n;
        reset = 1'b1; dot_en = 1'b0; line_start = 1'b0; frame_start = 1'b0;
        row = 3'd0; char_code = 6'd0; cursor_here = 1'b0; char_valid = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        row = 3'd1;

        // Two-cell line: 'A' then 'I', one dot per cycle
        start_line({1'b0, 6'h01}, {1'b0, 6'h09}, 1'b1);
        run_line("t2");
        check_dots("t2_video", 12'b001000_011100, 1, 12, 12);
        check("t2_rom0", hist.size() > 0 ? hist[0] : 9'h1ff, 9'h009);
        check("t2_rom1", hist.size() > 1 ? hist[1] : 9'h1ff, 9'h049);
        check("t2_underrun", underrun, 1'b0);

        // Only one character: second cell blank and underrun sticks until frame_start
        start_line({1'b0, 6'h01}, 7'd0, 1'b0);
        run_line("t3");
        check_dots("t3_video", 12'b001000_000000, 1, 12, 12);
        check("t3_underrun_set", underrun, 1'b1);
        repeat (3) tick();
        check("t3_underrun_hold", underrun, 1'b1);
        pulse_frame();
        check("t3_underrun_clr", underrun, 1'b0);

        // Reset held mid-line
        start_line({1'b0, 6'h01}, {1'b0, 6'h09}, 1'b1);
        n = 0;
        while (!active && n < 50) begin tick(); n++; end
        check("t1_started", active, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        feed.delete();
        repeat (3) tick();
        check("t1_video", video, 1'b0);
        check("t1_active", active, 1'b0);
        check("t1_ready", char_ready, 1'b0);
        check("t1_underrun", underrun, 1'b0);
        check("t1_rom_a", rom_a, 9'h100);
        reset = 1'b0;
        tick();

        // Cursor on 'B': plain glyph in phase 0, '@' after two frames
        start_line({1'b1, 6'h02}, 7'd0, 1'b0);
        run_line("t4a");
        check("t4_rom_p0", rom_a, 9'h011);
        check_dots("t4a_video", 12'b111100_000000, 1, 12, 6);
        pulse_frame();
        pulse_frame();
        start_line({1'b1, 6'h02}, 7'd0, 1'b0);
        run_line("t4b");
        check("t4_rom_p1", rom_a, 9'h001);
        check_dots("t4b_video", 12'b011100_000000, 1, 12, 6);
        pulse_frame();

        // Abort during the first cell with 'I' already prefetched
        start_line({1'b0, 6'h01}, {1'b0, 6'h09}, 1'b1);
        n = 0;
        while (!(active && feed.size() == 0) && n < 50) begin tick(); n++; end
        check("t5_prefetched", n < 50, 1'b1);
        pulse_line();
        check("t5_ready", char_ready, 1'b1);
        check("t5_active", active, 1'b0);
        cap.delete();
        hist.delete();
        feed.push_back({1'b0, 6'h03});
        feed.push_back({1'b0, 6'h04});
        run_line("t5");
        pat5 = {rom_fn(9'h019), 1'b0, rom_fn(9'h021), 1'b0};
        check_dots("t5_video", pat5, 1, 12, 12);
        check("t5_rom0", hist.size() > 0 ? hist[0] : 9'h1ff, 9'h019);
        check("t5_underrun", underrun, 1'b0);

        // Same line as the first case with a dot every third cycle
        dot_every = 3;
        start_line({1'b0, 6'h01}, {1'b0, 6'h09}, 1'b1);
        run_line("t6");
        check_dots("t6_video", 12'b001000_011100, 3, 36, 12);
        check("t6_underrun", underrun, 1'b0);
        dot_every = 1;

        // Random traffic against the model
        rand_mode = 1'b1;
        repeat (4000) tick();
        rand_mode = 1'b0;
        reset = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
